// File: rtl/pipe_hazard_ctrl.sv
// Interlock and issue controller for the 5-stage MIPS32 pipeline: a per-register
// write scoreboard stalls ID on RAW hazards, branches freeze fetch, and HLT latches.
module pipe_hazard_ctrl #(
    parameter int WB_LAT = 3,
    parameter int BR_LAT = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [31:0]      id_ir,
    output logic             stall_if,
    output logic             bubble_ex,
    output logic             issue,
    output logic             halted,
    output logic [31:0]      busy_mask,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int SbW = $clog2(WB_LAT + 1);
    localparam int BrW = $clog2(BR_LAT + 1);

    typedef enum logic [1:0] {RUN, BR_WAIT, HALT} state_e;

    state_e           state_q;
    logic [BrW-1:0]   brCnt_q;
    logic [CNT_W-1:0] stallCnt_q;
    logic [SbW-1:0]   sbCnt_q [1:31];

    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd, dstReg;
    logic        useRs, useRt, isBranch, isHalt;
    logic [31:0] busyVec, lateVec;
    logic        depHit;
    logic        unusedIrBits;

    assign opcode       = id_ir[31:26];
    assign rs           = id_ir[25:21];
    assign rt           = id_ir[20:16];
    assign rd           = id_ir[15:11];
    assign unusedIrBits = ^id_ir[10:0];

    always_comb begin
        useRs    = 1'b0;
        useRt    = 1'b0;
        dstReg   = 5'd0;
        isBranch = 1'b0;
        isHalt   = 1'b0;
        case (opcode)
            6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5: begin
                useRs  = 1'b1;
                useRt  = 1'b1;
                dstReg = rd;
            end
            6'd8, 6'd10, 6'd11, 6'd12: begin
                useRs  = 1'b1;
                dstReg = rt;
            end
            6'd9: begin
                useRs = 1'b1;
                useRt = 1'b1;
            end
            6'd13, 6'd14: begin
                useRs    = 1'b1;
                isBranch = 1'b1;
            end
            6'd63:   isHalt = 1'b1;
            default: ;
        endcase
    end

    // A count of 1 means the write lands in WB this cycle and the register file
    // passes it straight to ID, so only counts above 1 block issue.
    always_comb begin
        busyVec = '0;
        lateVec = '0;
        for (int k = 1; k < 32; k++) begin
            busyVec[k] = (sbCnt_q[k] != '0);
            lateVec[k] = (sbCnt_q[k] > SbW'(1));
        end
    end

    assign depHit = id_valid & ((useRs & lateVec[rs]) | (useRt & lateVec[rt]));

    always_comb begin
        stall_if  = 1'b0;
        bubble_ex = 1'b0;
        issue     = 1'b0;
        case (state_q)
            RUN: begin
                stall_if  = depHit;
                bubble_ex = depHit;
                issue     = id_valid & ~depHit;
            end
            default: begin
                stall_if  = 1'b1;
                bubble_ex = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            brCnt_q    <= '0;
            stallCnt_q <= '0;
        end else begin
            if (bubble_ex && state_q != HALT && stallCnt_q != '1)
                stallCnt_q <= stallCnt_q + 1'b1;
            case (state_q)
                RUN: begin
                    if (issue && isBranch) begin
                        state_q <= BR_WAIT;
                        brCnt_q <= BrW'(BR_LAT);
                    end else if (issue && isHalt) begin
                        state_q <= HALT;
                    end
                end
                BR_WAIT: begin
                    brCnt_q <= brCnt_q - 1'b1;
                    if (brCnt_q == BrW'(1))
                        state_q <= RUN;
                end
                HALT: begin
                end
                default: state_q <= RUN;
            endcase
        end
    end

    // Issue reload wins over the decrement, so back-to-back writers restart the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k < 32; k++)
                sbCnt_q[k] <= '0;
        end else begin
            for (int k = 1; k < 32; k++) begin
                if (issue && dstReg == 5'(k))
                    sbCnt_q[k] <= SbW'(WB_LAT);
                else if (sbCnt_q[k] != '0)
                    sbCnt_q[k] <= sbCnt_q[k] - 1'b1;
            end
        end
    end

    assign halted    = (state_q == HALT);
    assign busy_mask = busyVec;
    assign stall_cnt = stallCnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios plus random instruction
// streams, compared every cycle against a cycle-number based reference model.
module tb_pipe_hazard_ctrl;
    localparam int WB_LAT = 3;
    localparam int BR_LAT = 2;
    localparam int CNT_W  = 16;

    localparam logic [5:0] OP_ADD = 6'd0, OP_OR = 6'd3, OP_ADDI = 6'd10;
    localparam logic [5:0] OP_BNEQZ = 6'd13, OP_BEQZ = 6'd14, OP_HLT = 6'd63;

    logic             clk;
    logic             rst_n;
    logic             id_valid;
    logic [31:0]      id_ir;
    logic             stall_if;
    logic             bubble_ex;
    logic             issue;
    logic             halted;
    logic [31:0]      busy_mask;
    logic [CNT_W-1:0] stall_cnt;

    int testsRun  = 0;
    int failCount = 0;

    // Reference model: absolute cycle numbers of the last write per register,
    // the last frozen cycle after a branch, and the halt/stall bookkeeping.
    int cyc;
    int lastWr [32];
    int freezeEnd;
    bit haltM;
    int stallM;

    pipe_hazard_ctrl #(.WB_LAT(WB_LAT), .BR_LAT(BR_LAT), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .id_valid  (id_valid),
        .id_ir     (id_ir),
        .stall_if  (stall_if),
        .bubble_ex (bubble_ex),
        .issue     (issue),
        .halted    (halted),
        .busy_mask (busy_mask),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] rd);
        return {op, rs, rt, rd, 11'd0};
    endfunction

    function automatic void decodeRef(input logic [31:0] ir, output bit useRs, output bit useRt,
                                      output int dst, output bit br, output bit hlt);
        int op;
        op = int'(ir[31:26]);
        useRs = 0; useRt = 0; dst = 0; br = 0; hlt = 0;
        if (op <= 5) begin
            useRs = 1; useRt = 1; dst = int'(ir[15:11]);
        end else if (op == 8 || (op >= 10 && op <= 12)) begin
            useRs = 1; dst = int'(ir[20:16]);
        end else if (op == 9) begin
            useRs = 1; useRt = 1;
        end else if (op == 13 || op == 14) begin
            useRs = 1; br = 1;
        end else if (op == 63) begin
            hlt = 1;
        end
    endfunction

    function automatic bit notReadable(input int r);
        return (r != 0) && (cyc < lastWr[r] + WB_LAT);
    endfunction

    task automatic resetModel();
        cyc = 0;
        for (int k = 0; k < 32; k++) lastWr[k] = -100;
        freezeEnd = -1;
        haltM = 0;
        stallM = 0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive ID, compare every output to the model, then advance.
    task automatic applyStimulus(input logic v, input logic [31:0] ir, output logic issued);
        bit useRs, useRt, br, hlt, frozen, hazard, expStall, expIssue;
        int dst;
        logic [31:0] expBusy;
        id_valid = v;
        id_ir    = ir;
        #2;
        decodeRef(ir, useRs, useRt, dst, br, hlt);
        frozen   = haltM || (cyc <= freezeEnd);
        hazard   = v && ((useRs && notReadable(int'(ir[25:21]))) ||
                         (useRt && notReadable(int'(ir[20:16]))));
        expStall = frozen || hazard;
        expIssue = !frozen && v && !hazard;
        expBusy  = '0;
        for (int k = 1; k < 32; k++)
            expBusy[k] = (cyc > lastWr[k]) && (cyc <= lastWr[k] + WB_LAT);
        checkOutput("stall_if",  {31'd0, stall_if},  {31'd0, expStall});
        checkOutput("bubble_ex", {31'd0, bubble_ex}, {31'd0, expStall});
        checkOutput("issue",     {31'd0, issue},     {31'd0, expIssue});
        checkOutput("halted",    {31'd0, halted},    {31'd0, haltM});
        checkOutput("busy_mask", busy_mask, expBusy);
        checkOutput("stall_cnt", {16'd0, stall_cnt}, 32'(stallM));
        issued = issue;
        if (expStall && !haltM && stallM < (1 << CNT_W) - 1) stallM++;
        if (expIssue) begin
            if (dst != 0) lastWr[dst] = cyc;
            if (br) freezeEnd = cyc + BR_LAT;
            if (hlt) haltM = 1;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic issueHold(input logic [31:0] ir, output int bubbles);
        logic iss;
        bubbles = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, ir, iss);
            if (iss) return;
            bubbles++;
        end
        testsRun++;
        failCount++;
        $error("[TB] FAIL hold_timeout: observed no issue expected issue within 20 cycles");
    endtask

    task automatic idle(input int n);
        logic iss;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'd0, iss);
    endtask

    task automatic resetMidCycle(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput({tag, "_busy"},  busy_mask, 32'd0);
        checkOutput({tag, "_stall"}, {31'd0, stall_if},  32'd0);
        checkOutput({tag, "_bub"},   {31'd0, bubble_ex}, 32'd0);
        checkOutput({tag, "_cnt"},   {16'd0, stall_cnt}, 32'd0);
        checkOutput({tag, "_halt"},  {31'd0, halted},    32'd0);
        checkOutput({tag, "_issue"}, {31'd0, issue},     {31'd0, id_valid});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        resetModel();
    endtask

    initial begin
        int b;
        logic iss;
        logic [5:0] ops [14];
        ops = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd8, 6'd9,
                6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd32};
        rst_n    = 1'b0;
        id_valid = 1'b0;
        id_ir    = 32'd0;
        resetModel();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Independent stream
        issueHold(mk(OP_ADDI, 5'd0, 5'd1, 5'd0), b);
        checkOutput("indep1_bubbles", 32'(b), 32'd0);
        issueHold(mk(OP_ADDI, 5'd0, 5'd2, 5'd0), b);
        issueHold(mk(OP_ADDI, 5'd0, 5'd3, 5'd0), b);
        checkOutput("indep_busy", busy_mask, 32'h0000000E);
        idle(4);

        // RAW through R1
        issueHold(mk(OP_ADDI, 5'd0, 5'd1, 5'd0), b);
        issueHold(mk(OP_ADD, 5'd1, 5'd2, 5'd4), b);
        checkOutput("raw_bubbles", 32'(b), 32'(WB_LAT - 1));
        checkOutput("raw_stall_cnt", {16'd0, stall_cnt}, 32'd2);
        idle(4);

        // Chain with an intervening independent op, then R0 sources
        issueHold(mk(OP_ADD, 5'd1, 5'd2, 5'd4), b);
        issueHold(mk(OP_OR, 5'd7, 5'd7, 5'd7), b);
        issueHold(mk(OP_ADD, 5'd4, 5'd3, 5'd5), b);
        checkOutput("chain_bubbles", 32'(b), 32'd1);
        issueHold(mk(OP_ADDI, 5'd0, 5'd0, 5'd0), b);
        issueHold(mk(OP_ADD, 5'd0, 5'd0, 5'd6), b);
        checkOutput("r0_bubbles", 32'(b), 32'd0);
        idle(4);

        // Branch freeze, then a branch waiting on its source
        issueHold(mk(OP_BEQZ, 5'd1, 5'd0, 5'd0), b);
        issueHold(mk(OP_ADDI, 5'd0, 5'd2, 5'd0), b);
        checkOutput("br_freeze", 32'(b), 32'(BR_LAT));
        issueHold(mk(OP_ADDI, 5'd0, 5'd1, 5'd0), b);
        issueHold(mk(OP_BNEQZ, 5'd1, 5'd0, 5'd0), b);
        checkOutput("br_dep_bubbles", 32'(b), 32'd2);
        issueHold(mk(OP_ADDI, 5'd0, 5'd3, 5'd0), b);
        checkOutput("br_dep_freeze", 32'(b), 32'(BR_LAT));

        // Reset mid-RAW-stall and in BR_WAIT
        issueHold(mk(OP_ADDI, 5'd0, 5'd1, 5'd0), b);
        applyStimulus(1'b1, mk(OP_ADD, 5'd1, 5'd2, 5'd4), iss);
        id_valid = 1'b1;
        resetMidCycle("rst_raw");
        issueHold(mk(OP_ADD, 5'd1, 5'd2, 5'd4), b);
        checkOutput("rst_raw_after", 32'(b), 32'd0);
        issueHold(mk(OP_BEQZ, 5'd0, 5'd0, 5'd0), b);
        applyStimulus(1'b1, mk(OP_ADDI, 5'd0, 5'd2, 5'd0), iss);
        resetMidCycle("rst_br");
        issueHold(mk(OP_ADDI, 5'd0, 5'd2, 5'd0), b);
        checkOutput("rst_br_after", 32'(b), 32'd0);

        // Random stream over a small register set to provoke hazards
        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom_range(0, 3) != 0),
                          {ops[$urandom_range(0, 13)], 5'($urandom_range(0, 7)),
                           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 11'($urandom)},
                          iss);
        end
        idle(4);

        // HLT latches and the scoreboard drains
        issueHold(mk(OP_ADDI, 5'd0, 5'd5, 5'd0), b);
        issueHold(mk(OP_HLT, 5'd0, 5'd0, 5'd0), b);
        for (int i = 0; i < WB_LAT + 2; i++)
            applyStimulus(1'b1, mk(OP_ADDI, 5'd0, 5'd6, 5'd0), iss);
        checkOutput("hlt_halted", {31'd0, halted},   32'd1);
        checkOutput("hlt_stall",  {31'd0, stall_if}, 32'd1);
        checkOutput("hlt_busy",   busy_mask, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
